// File: rtl/nf_be_le_skid_converter.sv
// nf_be_le_skid_converter
//
// Purpose:
//   Egress-side AXI4-Stream converter from big-endian to little-endian byte
//   order. It reverses the byte lanes of tdata and the bits of tkeep. tuser
//   and tlast pass through unchanged. The return path is fully registered by
//   a two-entry skid buffer: an output register plus one skid register. The
//   block also counts accepted packets. It can optionally check tkeep framing
//   in the big-endian domain.
//
// Configuration:
//   NF_BE_LE_KEEP_CHECK_EN - when defined, every accepted beat is framing-checked.
//                            When undefined, pkt_err and stat_err_count are
//                            tied to 0.
//
// Ports:
//   clk, reset      - sole clock and synchronous active-high reset
//   s_axis_*        - big-endian slave stream (tdata/tkeep/tuser/tvalid/tlast/tready)
//   m_axis_*        - little-endian master stream (same signal set)
//   stat_pkt_count  - accepted tlast beats, wraps
//   stat_err_count  - framing errors, saturates
//   pkt_err         - one-cycle pulse per framing error

module nf_be_le_skid_converter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_COUNT_WIDTH      = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic [C_COUNT_WIDTH-1:0]        stat_pkt_count,
    output logic [C_COUNT_WIDTH-1:0]        stat_err_count,
    output logic                            pkt_err
);

    localparam int N  = C_AXIS_DATA_WIDTH / 8;
    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int UW = C_AXIS_TUSER_WIDTH;

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    logic          accept;
    logic          emit;
    logic [DW-1:0] convData;
    logic [N-1:0]  convKeep;

    logic [DW-1:0] outData_q, outData_d;
    logic [N-1:0]  outKeep_q, outKeep_d;
    logic [UW-1:0] outUser_q, outUser_d;
    logic          outLast_q, outLast_d;
    logic          outValid_q, outValid_d;

    logic [DW-1:0] skidData_q, skidData_d;
    logic [N-1:0]  skidKeep_q, skidKeep_d;
    logic [UW-1:0] skidUser_q, skidUser_d;
    logic          skidLast_q, skidLast_d;
    logic          skidValid_q, skidValid_d;

    logic          sReady_q, sReady_d;

    state_t                 state_q;
    logic [C_COUNT_WIDTH-1:0] pktCount_q;
    logic                   unusedStateBit;

    assign accept = s_axis_tvalid & sReady_q;
    assign emit   = outValid_q & m_axis_tready;

    // Byte-lane reversal is applied on the way in, so both buffer entries
    // already hold little-endian beats.
    always_comb begin
        convData = '0;
        convKeep = '0;
        for (int i = 0; i < N; i++) begin
            convData[8*i +: 8] = s_axis_tdata[8*(N-1-i) +: 8];
            convKeep[i]        = s_axis_tkeep[N-1-i];
        end
    end

    // Skid buffer steering. When the output register frees up, the skid
    // entry takes priority. It is older than anything on the slave port,
    // and the slave port is closed while the skid is full anyway. A beat
    // that arrives while the output is stalled parks in the skid. The
    // registered ready is computed from the next skid state, so it drops
    // exactly one cycle after the stalled accept.
    always_comb begin
        outData_d   = outData_q;
        outKeep_d   = outKeep_q;
        outUser_d   = outUser_q;
        outLast_d   = outLast_q;
        outValid_d  = outValid_q;
        skidData_d  = skidData_q;
        skidKeep_d  = skidKeep_q;
        skidUser_d  = skidUser_q;
        skidLast_d  = skidLast_q;
        skidValid_d = skidValid_q;
        if (!outValid_q || emit) begin
            if (skidValid_q) begin
                outData_d   = skidData_q;
                outKeep_d   = skidKeep_q;
                outUser_d   = skidUser_q;
                outLast_d   = skidLast_q;
                outValid_d  = 1'b1;
                skidValid_d = 1'b0;
            end else if (accept) begin
                outData_d  = convData;
                outKeep_d  = convKeep;
                outUser_d  = s_axis_tuser;
                outLast_d  = s_axis_tlast;
                outValid_d = 1'b1;
            end else begin
                outValid_d = 1'b0;
            end
        end else if (accept) begin
            skidData_d  = convData;
            skidKeep_d  = convKeep;
            skidUser_d  = s_axis_tuser;
            skidLast_d  = s_axis_tlast;
            skidValid_d = 1'b1;
        end
        sReady_d = !skidValid_d;
    end

    // Buffer registers. Reset empties both entries, so a packet that is cut
    // by reset leaves no tail behind. Ready is held low for the reset cycle
    // itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            outData_q   <= '0;
            outKeep_q   <= '0;
            outUser_q   <= '0;
            outLast_q   <= 1'b0;
            outValid_q  <= 1'b0;
            skidData_q  <= '0;
            skidKeep_q  <= '0;
            skidUser_q  <= '0;
            skidLast_q  <= 1'b0;
            skidValid_q <= 1'b0;
            sReady_q    <= 1'b0;
        end else begin
            outData_q   <= outData_d;
            outKeep_q   <= outKeep_d;
            outUser_q   <= outUser_d;
            outLast_q   <= outLast_d;
            outValid_q  <= outValid_d;
            skidData_q  <= skidData_d;
            skidKeep_q  <= skidKeep_d;
            skidUser_q  <= skidUser_d;
            skidLast_q  <= skidLast_d;
            skidValid_q <= skidValid_d;
            sReady_q    <= sReady_d;
        end
    end

    // Packet tracking on accepted beats. The counter wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pktCount_q <= '0;
        end else if (accept) begin
            if (s_axis_tlast) begin
                pktCount_q <= pktCount_q + 1'b1;
            end
            case (state_q)
                IDLE:    state_q <= s_axis_tlast ? IDLE : IN_PKT;
                IN_PKT:  state_q <= s_axis_tlast ? IDLE : IN_PKT;
                default: state_q <= IDLE;
            endcase
        end
    end

    // The packet state is kept for debug visibility only.
    assign unusedStateBit = (state_q == IN_PKT);

`ifdef NF_BE_LE_KEEP_CHECK_EN
    logic [N-1:0]             keepInv;
    logic                     keepBad;
    logic                     pktErr_q;
    logic [C_COUNT_WIDTH-1:0] errCount_q;

    // A valid last beat has keep = ones from the MSB followed by zeros. Its
    // inverse is then a low-order run of ones, and x & (x+1) == 0 tests for
    // that.
    always_comb begin
        keepInv = ~s_axis_tkeep;
        if (!s_axis_tlast) begin
            keepBad = (s_axis_tkeep != '1);
        end else begin
            keepBad = (s_axis_tkeep == '0) || ((keepInv & (keepInv + N'(1))) != '0);
        end
    end

    // Error pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pktErr_q   <= 1'b0;
            errCount_q <= '0;
        end else begin
            pktErr_q <= accept & keepBad;
            if (accept && keepBad && (errCount_q != '1)) begin
                errCount_q <= errCount_q + 1'b1;
            end
        end
    end

    assign pkt_err        = pktErr_q;
    assign stat_err_count = errCount_q;
`else
    assign pkt_err        = 1'b0;
    assign stat_err_count = '0;
`endif

    assign s_axis_tready  = sReady_q;
    assign m_axis_tdata   = outData_q;
    assign m_axis_tkeep   = outKeep_q;
    assign m_axis_tuser   = outUser_q;
    assign m_axis_tlast   = outLast_q;
    assign m_axis_tvalid  = outValid_q;
    assign stat_pkt_count = pktCount_q;

endmodule
